config_chain_loader: RTL and testbench
======================================

// Module: config_chain_loader
// PURPOSE
//  Drives the LUT configuration scan chain (config_in / config_en in, config_out back).
//  Load: serialises a word-wide bitstream into the chain.
//  Readback: recirculates the chain non-destructively and returns its contents as words.
//  Sits between the bitstream source (host or ROM) and the first LUT of the daisy chain.
//  After the last LUT, its config_out returns to this block.
// PARAMETERS
//  CHAIN_LEN  16                     total bits in the attached chain (sum of LUT reg_size)
//  WORD_W     8                      width of the bitstream word interfaces
//  CNT_W      $clog2(CHAIN_LEN+1)    width of the remaining-bit counter
// PORTS
//  config_clk  in   1       single clock; the attached chain shifts on its rising edge
//  config_rst  in   1       synchronous, active-high reset
//  load_start  in   1       pulse in IDLE: begin a load pass
//  read_start  in   1       pulse in IDLE: begin a readback pass
//  wr_data     in   WORD_W  load word; MSB is shifted first
//  wr_valid    in   1       wr_data valid
//  wr_ready    out  1       load word accepted when wr_valid && wr_ready
//  rd_data     out  WORD_W  readback word; MSB is the first bit out of the chain
//  rd_valid    out  1       rd_data valid; held stable until rd_ready
//  rd_ready    in   1       sink accepts rd_data
//  busy        out  1       high in LOAD / READ / DONE
//  done        out  1       one-cycle pulse at end of a pass
//  config_in   out  1       serial data to the chain head
//  config_en   out  1       chain shift enable
//  config_out  in   1       serial data from the chain tail
// BEHAVIOUR
//  Reset values: state=IDLE; wr_ready, rd_valid, busy, done = 0; rd_data = 0.
//  config_en is forced 0 combinationally while config_rst is high.
//  Port roles:
//   - config_en and config_in are combinational from internal registers.
//   - config_out is sampled in the same cycle config_en=1, before the shift edge.
//  Bit order: first bit shifted ends in the farthest chain position (MSB of the last LUT).
//  Bit order is identical for load and readback.
//  States: IDLE -> LOAD | READ -> DONE -> IDLE.
//  IDLE:
//   - load_start moves to LOAD; read_start moves to READ.
//   - Both asserted together: load wins and read_start is dropped.
//   - Starts outside IDLE are ignored.
//   - On entry to LOAD or READ, remaining counter = CHAIN_LEN.
//  LOAD:
//   - One word buffer plus a bit index.
//   - wr_ready = buffer empty OR last buffered bit shifting this cycle (no bubble).
//   - config_en = buffer holds a bit; config_in = current buffer MSB-side bit.
//   - Each enabled cycle decrements remaining.
//   - Empty buffer: config_en=0 and the chain holds; stalls are legal at any bit.
//   - remaining reaches 0: go to DONE and discard unused low bits of the last word.
//   - wr_ready is 0 in the cycle of the final shift.
//  READ:
//   - config_in = config_out (recirculate); config_en=1 unless stalled.
//   - Captured bits shift into a capture register, MSB first.
//   - Word complete (WORD_W bits, or remaining hits 0): move to rd_data and assert rd_valid.
//   - Final word is left-aligned, low bits zero.
//   - Stall (config_en=0) only when the capture register is full and rd_valid && !rd_ready.
//   - After the last bit has been shifted, wait until the final word is accepted, then go to DONE.
//   - After exactly CHAIN_LEN shifts the chain contents are unchanged.
//  DONE: done=1 for one cycle, then IDLE.
//  Latency:
//   - Continuous wr_valid: CHAIN_LEN back-to-back config_en cycles.
//   - The first shift is in the cycle after the first word is accepted.
//   - done follows the last shift by one cycle.
//  Mid-pass reset: aborts at the next edge.
//   - The chain keeps any partial contents; no further shifts occur.
//   - The next pass restarts from bit 0.
//  Words per pass = ceil(CHAIN_LEN/WORD_W).
// STRUCTURE
//  Shared package holds:
//   - state encoding localparams: IDLE, LOAD, READ, DONE;
//   - the bit-order convention constant.
//  One natural sub-module: cfg_word_serdes.
//   - Word<->bit shifter with bit index.
//   - Used as serialiser in LOAD and deserialiser in READ.
//  FSM, remaining counter and handshakes live in the top module.
// TESTING
//  Bench instantiates config_chain_loader with a chain of real LUT instances.
//  1. CHAIN_LEN=16, WORD_W=8, one K=4 LUT; load 0xA5,0x3C, wr_valid continuous:
//     -> 16 consecutive config_en cycles;
//     -> config_in = 1010_0101_0011_1100;
//     -> LUT_reg = 0xA53C, done pulses once.
//  2. Readback after test 1 -> rd_data 0xA5 then 0x3C; LUT_reg still 0xA53C.
//  3. Load with wr_valid low for 3 cycles between words:
//     -> config_en low exactly 3 cycles; final LUT_reg = 0xA53C.
//  4. Readback with rd_ready low for 10 cycles after the first rd_valid:
//     -> config_en stalls after 16 total captured bits, with none lost;
//     -> words 0xA5, 0x3C.
//  5. CHAIN_LEN=12; load 0xAB,0xCD:
//     -> 12 shifts; chain = 0xABC; low nibble of 0xCD dropped;
//     -> readback gives 0xAB, 0xC0.
//  6. Reset during LOAD after 5 shifts:
//     -> config_en=0 in the reset cycle; busy, wr_ready = 0 next cycle;
//     -> a fresh load of 0x12,0x34 gives LUT_reg=0x1234.
//     Also: load_start and read_start in the same cycle -> LOAD only.

Source files
------------

// File: rtl/config_chain_loader_pkg.sv
// Shared definitions for the configuration scan-chain loader: FSM state encoding
// and the serial bit-order convention used by both load and readback.
package config_chain_loader_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] READ = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // First bit on the wire is the word MSB; it lands in the farthest chain position.
    localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/config_chain_loader_serdes.sv
// Word<->bit shifter with a bit count: serialiser (cnt = bits left) during load,
// deserialiser (cnt = bits captured, left-aligned) during readback.
module cfg_word_serdes
    import config_chain_loader_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int IDX_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic              shift_out,
    input  logic              shift_in,
    input  logic              din,
    output logic [WORD_W-1:0] word,
    output logic [IDX_W-1:0]  cnt,
    output logic              ser_bit
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    int                pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    // Apply order: shift out, clear, shift in, load; lets a capture restart in the
    // same cycle its full word is handed off, and a reload follow the last bit.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        pos    = 0;
        if (shift_out) begin
            word_d = MSB_FIRST ? {word_q[WORD_W-2:0], 1'b0} : {1'b0, word_q[WORD_W-1:1]};
            cnt_d  = cnt_q - IDX_W'(1);
        end
        if (clr) begin
            word_d = '0;
            cnt_d  = '0;
        end
        if (shift_in) begin
            pos = MSB_FIRST ? (WORD_W - 1 - int'(cnt_d)) : int'(cnt_d);
            for (int i = 0; i < WORD_W; i++) begin
                if (i == pos) word_d[i] = din;
            end
            cnt_d = cnt_d + IDX_W'(1);
        end
        if (load) begin
            word_d = load_word;
            cnt_d  = IDX_W'(WORD_W);
        end
    end

    assign word    = word_q;
    assign cnt     = cnt_q;
    assign ser_bit = MSB_FIRST ? word_q[WORD_W-1] : word_q[0];

endmodule

// File: rtl/config_chain_loader.sv
// Drives a LUT configuration scan chain: serial load from a word stream and
// non-destructive recirculating readback into a word stream.
module config_chain_loader
    import config_chain_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              config_clk,
    input  logic              config_rst,
    input  logic              load_start,
    input  logic              read_start,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              config_in,
    output logic              config_en,
    input  logic              config_out
);

    localparam int IDX_W = $clog2(WORD_W + 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic [WORD_W-1:0] sd_word;
    logic [IDX_W-1:0]  sd_cnt;
    logic              sd_msb;
    logic              sd_clr, sd_load, sd_shift_out, sd_shift_in;

    logic sd_empty, sd_full, last_shift, can_move, move, accept;

    cfg_word_serdes #(
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_serdes (
        .clk       (config_clk),
        .rst       (config_rst),
        .clr       (sd_clr),
        .load      (sd_load),
        .load_word (wr_data),
        .shift_out (sd_shift_out),
        .shift_in  (sd_shift_in),
        .din       (config_out),
        .word      (sd_word),
        .cnt       (sd_cnt),
        .ser_bit   (sd_msb)
    );

    always_ff @(posedge config_clk) begin
        if (config_rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_valid_q;
        sd_clr       = 1'b0;
        sd_load      = 1'b0;
        sd_shift_out = 1'b0;
        sd_shift_in  = 1'b0;
        if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                sd_clr = 1'b1;
                if (load_start) begin
                    state_d     = LOAD;
                    remaining_d = CNT_W'(CHAIN_LEN);
                end else if (read_start) begin
                    state_d     = READ;
                    remaining_d = CNT_W'(CHAIN_LEN);
                end
            end
            LOAD: begin
                sd_shift_out = config_en;
                sd_load      = accept;
                if (config_en) remaining_d = remaining_q - CNT_W'(1);
                // Last chain bit: unused low bits of the final word are dropped.
                if (config_en && last_shift) begin
                    state_d = DONE;
                    sd_clr  = 1'b1;
                end
            end
            READ: begin
                sd_clr      = move;
                sd_shift_in = config_en;
                if (config_en) remaining_d = remaining_q - CNT_W'(1);
                if (move) begin
                    rd_data_d  = sd_word;
                    rd_valid_d = 1'b1;
                end
                if (remaining_q == '0 && sd_empty && rd_valid_q && rd_ready) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        config_en  = 1'b0;
        config_in  = 1'b0;
        wr_ready   = 1'b0;
        move       = 1'b0;
        sd_empty   = (sd_cnt == '0);
        sd_full    = (sd_cnt == IDX_W'(WORD_W));
        last_shift = (remaining_q == CNT_W'(1));
        can_move   = !rd_valid_q || rd_ready;
        case (state_q)
            LOAD: begin
                config_en = !sd_empty;
                config_in = sd_msb;
                wr_ready  = sd_empty || (sd_cnt == IDX_W'(1) && !last_shift);
            end
            READ: begin
                config_in = config_out;
                config_en = (remaining_q != '0) && !(sd_full && !can_move);
                move      = (sd_full || (remaining_q == '0 && !sd_empty)) && can_move;
            end
            default: ;
        endcase
        if (config_rst) config_en = 1'b0;
        accept   = wr_valid && wr_ready;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        rd_data  = rd_data_q;
        rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: a 16-bit chain (one K=4 LUT) and a 12-bit chain
// (three K=2 LUTs), directed passes followed by randomized load/readback passes.
module tb_config_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst[2], load_start[2], read_start[2], wr_valid[2], rd_ready[2];
    logic [7:0] wr_data[2], rd_data[2];
    logic       wr_ready[2], rd_valid[2], busy[2], done[2];
    logic       config_in[2], config_en[2], config_out[2];

    // LUT configuration registers; a shift moves every bit one place toward the tail.
    logic [15:0] lut4_reg = '0;
    logic [3:0]  lut2_reg[3] = '{4'h0, 4'h0, 4'h0};

    always @(posedge clk) begin
        if (config_en[0]) lut4_reg <= {lut4_reg[14:0], config_in[0]};
        if (config_en[1]) begin
            lut2_reg[0] <= {lut2_reg[0][2:0], config_in[1]};
            lut2_reg[1] <= {lut2_reg[1][2:0], lut2_reg[0][3]};
            lut2_reg[2] <= {lut2_reg[2][2:0], lut2_reg[1][3]};
        end
    end
    assign config_out[0] = lut4_reg[15];
    assign config_out[1] = lut2_reg[2][3];

    config_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_dut16 (
        .config_clk(clk), .config_rst(rst[0]), .load_start(load_start[0]), .read_start(read_start[0]),
        .wr_data(wr_data[0]), .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]),
        .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]),
        .busy(busy[0]), .done(done[0]), .config_in(config_in[0]), .config_en(config_en[0]),
        .config_out(config_out[0]));

    config_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_dut12 (
        .config_clk(clk), .config_rst(rst[1]), .load_start(load_start[1]), .read_start(read_start[1]),
        .wr_data(wr_data[1]), .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]),
        .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]),
        .busy(busy[1]), .done(done[1]), .config_in(config_in[1]), .config_en(config_en[1]),
        .config_out(config_out[1]));

    int          checks = 0, failures = 0, cyc = 0;
    int          en_cnt[2], done_cnt[2], rd_n[2], first_en[2], last_en[2], stab_err[2];
    logic [31:0] en_shift[2];
    logic [7:0]  rd_w[2][4];
    bit          hold[2];
    logic [7:0]  hold_data[2];

    // Monitor samples late in the low phase, after the drivers have settled.
    always @(negedge clk) begin
        #3;
        for (int d = 0; d < 2; d++) begin
            if (config_en[d]) begin
                en_cnt[d]++;
                en_shift[d] = {en_shift[d][30:0], config_in[d]};
                if (first_en[d] < 0) first_en[d] = cyc;
                last_en[d] = cyc;
            end
            if (done[d]) done_cnt[d]++;
            if (hold[d] && (!rd_valid[d] || rd_data[d] !== hold_data[d])) stab_err[d]++;
            if (rd_valid[d] && rd_ready[d]) begin
                if (rd_n[d] < 4) rd_w[d][rd_n[d]] = rd_data[d];
                rd_n[d]++;
            end
            hold[d]      = rd_valid[d] && !rd_ready[d];
            hold_data[d] = rd_data[d];
        end
        cyc++;
    end

    function automatic int len_of(input int d);
        return (d == 0) ? 16 : 12;
    endfunction

    function automatic logic [15:0] chain_val(input int d);
        return (d == 0) ? lut4_reg : {4'h0, lut2_reg[2], lut2_reg[1], lut2_reg[0]};
    endfunction

    // Chain holds the first L bits of the word stream, the first bit at the far end.
    function automatic logic [15:0] model_chain(input int d, input logic [7:0] w0, input logic [7:0] w1);
        logic [15:0] s;
        s = {w0, w1};
        return s >> (16 - len_of(d));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon(input int d);
        en_cnt[d] = 0; done_cnt[d] = 0; rd_n[d] = 0; first_en[d] = -1; last_en[d] = -1;
        stab_err[d] = 0; en_shift[d] = '0; hold[d] = 1'b0;
    endtask

    task automatic wait_ready(input int d);
        int t = 0;
        #1;
        while (!wr_ready[d] && t < 100) begin @(negedge clk); #1; t++; end
        chk("wr_ready_seen", wr_ready[d], 1);
    endtask

    task automatic wait_idle(input int d);
        int t = 0;
        @(negedge clk); #1;
        while (busy[d] && t < 200) begin @(negedge clk); #1; t++; end
        chk("idle_reached", busy[d], 0);
        @(negedge clk);
    endtask

    // gap: cycles wr_valid stays low once the buffer could take the second word.
    task automatic do_load(input int d, input logic [7:0] w0, input logic [7:0] w1,
                           input int gap, input bit both);
        clr_mon(d);
        @(negedge clk); load_start[d] = 1'b1; read_start[d] = both;
        @(negedge clk); load_start[d] = 1'b0; read_start[d] = 1'b0;
        wr_data[d] = w0; wr_valid[d] = 1'b1;
        wait_ready(d);
        @(negedge clk); wr_valid[d] = 1'b0;
        if (gap > 0) begin
            wait_ready(d);
            repeat (gap) @(negedge clk);
        end
        wr_data[d] = w1; wr_valid[d] = 1'b1;
        wait_ready(d);
        @(negedge clk); wr_valid[d] = 1'b0;
        wait_idle(d);
    endtask

    task automatic check_load(input int d, input logic [7:0] w0, input logic [7:0] w1, input int gap);
        logic [31:0] mask;
        int          l;
        l    = len_of(d);
        mask = (32'd1 << l) - 32'd1;
        chk("load_chain", chain_val(d), model_chain(d, w0, w1));
        chk("load_shifts", en_cnt[d], l);
        chk("load_stream", en_shift[d] & mask, model_chain(d, w0, w1));
        chk("load_span", last_en[d] - first_en[d] + 1, l + gap);
        chk("load_done_pulses", done_cnt[d], 1);
        chk("load_no_read_words", rd_n[d], 0);
    endtask

    task automatic do_read(input int d, input int hold_cyc);
        int t = 0;
        clr_mon(d);
        @(negedge clk); read_start[d] = 1'b1; rd_ready[d] = (hold_cyc == 0);
        @(negedge clk); read_start[d] = 1'b0;
        if (hold_cyc > 0) begin
            #1;
            while (!rd_valid[d] && t < 100) begin @(negedge clk); #1; t++; end
            chk("rd_valid_seen", rd_valid[d], 1);
            repeat (hold_cyc) @(negedge clk);
            rd_ready[d] = 1'b1;
        end
        wait_idle(d);
    endtask

    // Readback words: chain contents split MSB-first into left-aligned words.
    task automatic check_read(input int d, input logic [15:0] cexp);
        logic [15:0] r;
        r = cexp << (16 - len_of(d));
        chk("read_words", rd_n[d], 2);
        chk("read_word0", rd_w[d][0], r[15:8]);
        chk("read_word1", rd_w[d][1], r[7:0]);
        chk("read_chain_kept", chain_val(d), cexp);
        chk("read_shifts", en_cnt[d], len_of(d));
        chk("read_done_pulses", done_cnt[d], 1);
        chk("read_hold_stable", stab_err[d], 0);
    endtask

    initial begin
        logic [15:0] prev, cexp;
        logic [7:0]  w0, w1;
        int          d, gap, hc, t;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; load_start[i] = 1'b0; read_start[i] = 1'b0;
            wr_valid[i] = 1'b0; wr_data[i] = '0; rd_ready[i] = 1'b1;
            clr_mon(i);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) rst[i] = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_wr_ready", wr_ready[i], 0);
            chk("rst_rd_valid", rd_valid[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_done", done[i], 0);
            chk("rst_rd_data", rd_data[i], 0);
            chk("rst_config_en", config_en[i], 0);
        end

        do_load(0, 8'hA5, 8'h3C, 0, 1'b0);
        check_load(0, 8'hA5, 8'h3C, 0);
        chk("t1_lut_reg", lut4_reg, 16'hA53C);

        do_read(0, 0);
        check_read(0, 16'hA53C);

        do_load(0, 8'hA5, 8'h3C, 3, 1'b0);
        check_load(0, 8'hA5, 8'h3C, 3);

        do_read(0, 10);
        check_read(0, 16'hA53C);

        do_load(1, 8'hAB, 8'hCD, 0, 1'b0);
        check_load(1, 8'hAB, 8'hCD, 0);
        chk("t5_chain12", chain_val(1), 16'h0ABC);
        do_read(1, 0);
        check_read(1, 16'h0ABC);
        chk("t5_word1_low_zero", rd_w[1][1], 8'hC0);

        // Reset five bits into a load.
        prev = lut4_reg;
        w0   = 8'($urandom);
        clr_mon(0);
        @(negedge clk); load_start[0] = 1'b1;
        @(negedge clk); load_start[0] = 1'b0; wr_data[0] = w0; wr_valid[0] = 1'b1;
        t = 0;
        while (en_cnt[0] < 5 && t < 100) begin @(negedge clk); t++; end
        rst[0] = 1'b1; wr_valid[0] = 1'b0;
        #1;
        chk("t6_en_in_reset", config_en[0], 0);
        @(negedge clk); rst[0] = 1'b0;
        #1;
        chk("t6_busy_after", busy[0], 0);
        chk("t6_wr_ready_after", wr_ready[0], 0);
        repeat (2) @(negedge clk);
        chk("t6_partial_shifts", en_cnt[0], 5);
        chk("t6_partial_chain", lut4_reg, 16'((prev << 5) | 16'(w0 >> 3)));
        do_load(0, 8'h12, 8'h34, 0, 1'b1);
        check_load(0, 8'h12, 8'h34, 0);
        chk("t6_lut_reg", lut4_reg, 16'h1234);

        for (int it = 0; it < 8; it++) begin
            d   = int'($urandom_range(0, 1));
            w0  = 8'($urandom);
            w1  = 8'($urandom);
            gap = int'($urandom_range(0, 4));
            hc  = int'($urandom_range(0, 8));
            do_load(d, w0, w1, gap, 1'($urandom_range(0, 1)));
            check_load(d, w0, w1, gap);
            cexp = model_chain(d, w0, w1);
            do_read(d, hc);
            check_read(d, cexp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
